// File: rtl/dma_gic_irq_ctrl_pkg.sv
// Shared types, constants and helpers for the DMA-to-GIC interrupt controller.
package dma_gic_irq_pkg;

    localparam int         NUM_GIC_LINES = 3;
    localparam logic [1:0] LINE_DROP     = 2'd3;
    // Width of a per-cycle increment: up to 16 sources can fire together.
    localparam int         INC_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } irq_line_state_e;

    // Number of set bits in a 16-bit source vector.
    function automatic logic [INC_W-1:0] popcount16(input logic [15:0] vec);
        logic [INC_W-1:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {{(INC_W-1){1'b0}}, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dma_gic_irq_ctrl_if.sv
// GIC-side interrupt interface: level lines, pending counts, busy flags and acks.
interface dma_gic_irq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [2:0]         irq_ack;
    logic [2:0]         interrupt;
    logic [3*CNT_W-1:0] irq_pend_cnt;
    logic [2:0]         irq_busy;

    modport master (
        input  irq_ack,
        output interrupt,
        output irq_pend_cnt,
        output irq_busy
    );

    modport slave (
        output irq_ack,
        input  interrupt,
        input  irq_pend_cnt,
        input  irq_busy
    );
endinterface

// File: rtl/dma_gic_irq_ctrl_line.sv
// One interrupt line: event coalescing (threshold + timeout), level hold until
// ack, and a forced-low holdoff window before the line may re-assert.
module dma_gic_irq_line
    import dma_gic_irq_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TMR_W       = 16,
    parameter int HOLDOFF_CYC = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [INC_W-1:0] inc_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic [TMR_W-1:0] timeout_i,
    input  logic             ack_i,
    output logic             irq_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy_o
);

    localparam int               HO_W    = $clog2(HOLDOFF_CYC + 1);
    localparam logic [HO_W-1:0]  HO_LAST = HO_W'(HOLDOFF_CYC - 1);
    localparam int               SW      = CNT_W + INC_W + 1;

    // Saturating count + increment, clamped at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SW'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end else begin
            return s[CNT_W-1:0];
        end
    endfunction

    irq_line_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [HO_W-1:0]  hold_q, hold_d;
    logic             irq_q, busy_q;

    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W-1:0] cnt_upd;
    logic [CNT_W-1:0] cnt_fresh;
    logic [TMR_W-1:0] tmr_inc;

    // Next-state, counter, timer and holdoff evaluation for this line.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        hold_d    = hold_q;
        thr_eff   = (thresh_i == '0) ? CNT_W'(1) : thresh_i;
        cnt_upd   = sat_add(cnt_q, inc_i);
        cnt_fresh = sat_add('0, inc_i);
        tmr_inc   = (tmr_q == {TMR_W{1'b1}}) ? tmr_q : tmr_q + TMR_W'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d  = cnt_fresh;
                tmr_d  = '0;
                hold_d = '0;
                if (inc_i != '0) begin
                    if (SW'(inc_i) >= SW'(thr_eff)) begin
                        state_d = ST_ASSERT;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                cnt_d = cnt_upd;
                tmr_d = tmr_inc;
                if ((cnt_upd >= thr_eff) ||
                    ((timeout_i != '0) && (tmr_inc >= timeout_i))) begin
                    state_d = ST_ASSERT;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ASSERT: begin
                if (ack_i) begin
                    // Events arriving with the ack start the next batch.
                    cnt_d   = cnt_fresh;
                    tmr_d   = '0;
                    hold_d  = '0;
                    state_d = ST_HOLDOFF;
                end else begin
                    cnt_d   = cnt_upd;
                end
            end
            ST_HOLDOFF: begin
                cnt_d = cnt_upd;
                if (hold_q == HO_LAST) begin
                    hold_d  = '0;
                    tmr_d   = '0;
                    state_d = (cnt_upd != '0) ? ST_ACCUM : ST_IDLE;
                end else begin
                    hold_d  = hold_q + HO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State/counter registers and registered output decode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            hold_q  <= '0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            hold_q  <= hold_d;
            irq_q   <= (state_q == ST_ASSERT);
            busy_q  <= (state_q != ST_IDLE);
        end
    end

    assign irq_o  = irq_q;
    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/dma_gic_irq_ctrl.sv
// Top level: steers enabled DMA event pulses to the three GIC lines and packs
// the per-line coalescing engines onto the GIC interface.
module dma_gic_irq_ctrl
    import dma_gic_irq_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int CNT_W       = 8,
    parameter int TMR_W       = 16,
    parameter int HOLDOFF_CYC = 4
) (
    input  logic                   user_clk,
    input  logic                   user_reset,
    input  logic [NUM_SRC-1:0]     src_event,
    input  logic [NUM_SRC-1:0]     cfg_src_en,
    input  logic [2*NUM_SRC-1:0]   cfg_src_line,
    input  logic [3*CNT_W-1:0]     cfg_thresh,
    input  logic [3*TMR_W-1:0]     cfg_timeout,
    dma_gic_irq_ctrl_if.master     gic
);

    logic [15:0]      sel_s [NUM_GIC_LINES];
    logic [INC_W-1:0] inc_s [NUM_GIC_LINES];
    logic [NUM_GIC_LINES-1:0] irq_s, busy_s;
    logic [NUM_GIC_LINES*CNT_W-1:0] cnt_s;

    // Per-line selection of enabled, non-dropped source pulses and their count.
    always_comb begin
        for (int l = 0; l < NUM_GIC_LINES; l++) begin
            sel_s[l] = 16'd0;
            for (int s = 0; s < NUM_SRC; s++) begin
                sel_s[l][s] = src_event[s] & cfg_src_en[s] &
                              (cfg_src_line[2*s +: 2] != LINE_DROP) &
                              (cfg_src_line[2*s +: 2] == 2'(l));
            end
            inc_s[l] = popcount16(sel_s[l]);
        end
    end

    for (genvar l = 0; l < NUM_GIC_LINES; l++) begin : g_line
        dma_gic_irq_line #(
            .CNT_W       (CNT_W),
            .TMR_W       (TMR_W),
            .HOLDOFF_CYC (HOLDOFF_CYC)
        ) u_line (
            .clk_i     (user_clk),
            .rst_i     (user_reset),
            .inc_i     (inc_s[l]),
            .thresh_i  (cfg_thresh[l*CNT_W +: CNT_W]),
            .timeout_i (cfg_timeout[l*TMR_W +: TMR_W]),
            .ack_i     (gic.irq_ack[l]),
            .irq_o     (irq_s[l]),
            .cnt_o     (cnt_s[l*CNT_W +: CNT_W]),
            .busy_o    (busy_s[l])
        );
    end

    assign gic.interrupt    = irq_s;
    assign gic.irq_pend_cnt = cnt_s;
    assign gic.irq_busy     = busy_s;

endmodule

// File: tb/tb_dma_gic_irq_ctrl.sv
// Directed + randomized bench for dma_gic_irq_ctrl with a behavioural line model.
module tb_dma_gic_irq_ctrl;

    localparam int NS   = 8;
    localparam int CW   = 8;
    localparam int TW   = 16;
    localparam int HO   = 4;
    localparam int CMAX = 255;
    localparam int TMAX = 65535;

    logic          user_clk = 1'b0;
    logic          user_reset;
    logic [NS-1:0] src_event;
    logic [NS-1:0] cfg_src_en;
    logic [2*NS-1:0] cfg_src_line;
    logic [3*CW-1:0] cfg_thresh;
    logic [3*TW-1:0] cfg_timeout;

    dma_gic_irq_ctrl_if #(.CNT_W(CW)) gic_if ();

    dma_gic_irq_ctrl #(
        .NUM_SRC(NS), .CNT_W(CW), .TMR_W(TW), .HOLDOFF_CYC(HO)
    ) dut (
        .user_clk     (user_clk),
        .user_reset   (user_reset),
        .src_event    (src_event),
        .cfg_src_en   (cfg_src_en),
        .cfg_src_line (cfg_src_line),
        .cfg_thresh   (cfg_thresh),
        .cfg_timeout  (cfg_timeout),
        .gic          (gic_if)
    );

    always #5 user_clk = ~user_clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: per line a pending count, an "armed" flag (level up),
    // a quiet countdown after ack, and an age (-1 when nothing is collecting).
    int m_pend  [3];
    bit m_armed [3];
    int m_quiet [3];
    int m_age   [3];
    bit m_irq   [3];
    bit m_busy  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int l = 0; l < 3; l++) begin
            int inc, thr, to;
            inc = 0;
            for (int s = 0; s < NS; s++) begin
                if (src_event[s] && cfg_src_en[s] && (int'(cfg_src_line[2*s +: 2]) == l))
                    inc++;
            end
            thr = int'(cfg_thresh[l*CW +: CW]);
            if (thr == 0) thr = 1;
            to  = int'(cfg_timeout[l*TW +: TW]);
            if (user_reset) begin
                m_pend[l] = 0; m_armed[l] = 0; m_quiet[l] = 0; m_age[l] = -1;
                m_irq[l] = 0; m_busy[l] = 0;
            end else begin
                m_irq[l]  = m_armed[l];
                m_busy[l] = m_armed[l] || (m_quiet[l] > 0) || (m_age[l] >= 0);
                if (m_armed[l]) begin
                    if (gic_if.irq_ack[l]) begin
                        m_pend[l] = (inc > CMAX) ? CMAX : inc;
                        m_armed[l] = 0; m_quiet[l] = HO; m_age[l] = -1;
                    end else begin
                        m_pend[l] = (m_pend[l] + inc > CMAX) ? CMAX : m_pend[l] + inc;
                    end
                end else if (m_quiet[l] > 0) begin
                    m_pend[l] = (m_pend[l] + inc > CMAX) ? CMAX : m_pend[l] + inc;
                    m_quiet[l]--;
                    if (m_quiet[l] == 0) m_age[l] = (m_pend[l] > 0) ? 0 : -1;
                end else if (m_age[l] >= 0) begin
                    m_pend[l] = (m_pend[l] + inc > CMAX) ? CMAX : m_pend[l] + inc;
                    m_age[l]  = (m_age[l] + 1 > TMAX) ? TMAX : m_age[l] + 1;
                    if (m_pend[l] >= thr || (to != 0 && m_age[l] >= to)) m_armed[l] = 1;
                end else begin
                    m_pend[l] = inc;
                    if (inc > 0) begin
                        if (inc >= thr) m_armed[l] = 1;
                        else m_age[l] = 0;
                    end
                end
            end
        end
    endtask

    // One clock: advance model with current inputs, then compare after the edge.
    task automatic tick();
        model_step();
        @(posedge user_clk);
        #1;
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("irq[%0d]", l), 32'(gic_if.interrupt[l]), 32'(m_irq[l]));
            chk($sformatf("busy[%0d]", l), 32'(gic_if.irq_busy[l]), 32'(m_busy[l]));
            chk($sformatf("pend[%0d]", l), 32'(gic_if.irq_pend_cnt[l*CW +: CW]), 32'(m_pend[l]));
        end
    endtask

    task automatic tick_with(input logic [NS-1:0] ev, input logic [2:0] ack);
        src_event      = ev;
        gic_if.irq_ack = ack;
        tick();
        src_event      = '0;
        gic_if.irq_ack = 3'd0;
    endtask

    task automatic set_line(input int s, input logic [1:0] l);
        cfg_src_line[2*s +: 2] = l;
    endtask

    initial begin
        user_reset     = 1'b1;
        src_event      = '0;
        cfg_src_en     = '0;
        cfg_src_line   = '1;
        cfg_thresh     = '0;
        cfg_timeout    = '0;
        gic_if.irq_ack = 3'd0;
        for (int l = 0; l < 3; l++) m_age[l] = -1;

        repeat (3) tick();
        chk("rst_irq", 32'(gic_if.interrupt), 32'd0);
        chk("rst_pend", gic_if.irq_pend_cnt, 32'd0);
        user_reset = 1'b0;

        // Threshold path on line 1.
        cfg_src_en   = 8'hff;
        cfg_src_line = 16'hffff;
        set_line(2, 2'd1);
        cfg_thresh   = {8'd1, 8'd1, 8'd1};
        cfg_timeout  = '0;
        repeat (2) tick();
        tick_with(8'h04, 3'd0);
        chk("thr_lat0", 32'(gic_if.interrupt[1]), 32'd0);
        tick();
        chk("thr_irq", 32'(gic_if.interrupt[1]), 32'd1);
        chk("thr_cnt", 32'(gic_if.irq_pend_cnt[15:8]), 32'd1);
        repeat (3) tick();
        tick_with('0, 3'b010);
        tick();
        chk("ack_low", 32'(gic_if.interrupt[1]), 32'd0);
        repeat (3) tick();
        chk("ho_busy", 32'(gic_if.irq_busy[1]), 32'd1);
        tick();
        chk("ho_idle", 32'(gic_if.irq_busy[1]), 32'd0);

        // Coalescing on line 0: timeout path.
        set_line(0, 2'd0);
        cfg_thresh[7:0]   = 8'd4;
        cfg_timeout[15:0] = 16'd100;
        for (int i = 0; i < 3; i++) begin tick_with(8'h01, 3'd0); tick(); end
        chk("coal_noirq", 32'(gic_if.interrupt[0]), 32'd0);
        chk("coal_cnt", 32'(gic_if.irq_pend_cnt[7:0]), 32'd3);
        repeat (100) tick();
        chk("tmo_irq", 32'(gic_if.interrupt[0]), 32'd1);
        chk("tmo_cnt", 32'(gic_if.irq_pend_cnt[7:0]), 32'd3);
        tick_with('0, 3'b001);
        repeat (6) tick();
        chk("tmo_idle", 32'(gic_if.irq_busy[0]), 32'd0);
        // Coalescing: threshold reached by the 4th pulse.
        for (int i = 0; i < 3; i++) begin tick_with(8'h01, 3'd0); tick(); end
        tick_with(8'h01, 3'd0);
        chk("c4_lat0", 32'(gic_if.interrupt[0]), 32'd0);
        tick();
        chk("c4_irq", 32'(gic_if.interrupt[0]), 32'd1);
        chk("c4_cnt", 32'(gic_if.irq_pend_cnt[7:0]), 32'd4);
        tick_with('0, 3'b001);
        repeat (6) tick();

        // Saturation with all sources on line 0.
        cfg_src_line    = 16'h0000;
        cfg_thresh[7:0] = 8'd1;
        cfg_timeout     = '0;
        repeat (40) tick_with(8'hff, 3'd0);
        chk("sat_cnt", 32'(gic_if.irq_pend_cnt[7:0]), 32'd255);
        chk("sat_irq", 32'(gic_if.interrupt[0]), 32'd1);

        // Ack with two simultaneous events.
        tick_with(8'h03, 3'b001);
        chk("ackev_cnt", 32'(gic_if.irq_pend_cnt[7:0]), 32'd2);
        repeat (5) tick();
        chk("ackev_low", 32'(gic_if.interrupt[0]), 32'd0);
        tick();
        chk("ackev_re", 32'(gic_if.interrupt[0]), 32'd1);
        chk("ackev_cnt2", 32'(gic_if.irq_pend_cnt[7:0]), 32'd2);
        tick_with('0, 3'b001);
        repeat (6) tick();

        // Masking and drop.
        cfg_src_line = 16'hffff;
        set_line(5, 2'd2);
        cfg_src_en   = 8'hdf;
        tick_with(8'h60, 3'd0);
        tick();
        chk("mask_pend", gic_if.irq_pend_cnt, 32'd0);
        chk("mask_busy", 32'(gic_if.irq_busy), 32'd0);
        tick_with('0, 3'b111);
        tick();
        chk("idle_ack", 32'(gic_if.irq_busy), 32'd0);

        // Reset mid-ASSERT with 7 counted events on line 2.
        cfg_src_en      = 8'hff;
        cfg_src_line    = 16'heaaa;
        cfg_thresh[23:16] = 8'd1;
        tick_with(8'h7f, 3'd0);
        tick();
        chk("pre_rst_cnt", 32'(gic_if.irq_pend_cnt[23:16]), 32'd7);
        chk("pre_rst_irq", 32'(gic_if.interrupt[2]), 32'd1);
        user_reset = 1'b1;
        tick_with(8'h7f, 3'd0);
        user_reset = 1'b0;
        chk("rst_irq2", 32'(gic_if.interrupt), 32'd0);
        chk("rst_busy2", 32'(gic_if.irq_busy), 32'd0);
        chk("rst_pend2", gic_if.irq_pend_cnt, 32'd0);
        repeat (2) tick();
        chk("rst_drop", gic_if.irq_pend_cnt, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                cfg_src_en   = 8'($urandom);
                cfg_src_line = 16'($urandom);
                for (int l = 0; l < 3; l++) begin
                    cfg_thresh[l*CW +: CW]  = 8'($urandom_range(0, 6));
                    cfg_timeout[l*TW +: TW] = 16'($urandom_range(0, 20));
                end
            end
            tick_with(8'($urandom) & 8'($urandom),
                      {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
